decoder_rr_scheduler: RTL and testbench
=======================================

Name: decoder_rr_scheduler

Overview:
- Round-robin scheduler that shares one 3-to-8 decoder-driven resource among 8 requesters.
- Picks one requester, drives the 3-bit select (A[2:0], A[2]=MSB) and a gated one-hot enable.
- Holds the grant until the requester releases or a hold timeout expires.
- Inserts one dead cycle between grants (break-before-make), so no two enable lines are ever high together.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per requester; legal range 1..2**CNT_W.
- CNT_W, 5, width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scheduler enable; gates new grants only
- req  input  8  request vector; req[i] from requester i
- grant_vld  output  1  a grant is active
- grant_idx  output  3  index of granted requester; drives decoder A[2:0]
- grant_onehot  output  8  bit i = 1 iff grant_vld and grant_idx==i
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state=IDLE, grant_vld=0, grant_idx=0, grant_onehot=0, timeout=0, hold_cnt=0, last_ptr=7 (first search starts at index 0).

- States: IDLE, GRANT, GAP.

- IDLE
  - If en=1 and req!=0, select the first i with req[i]=1, searching last_ptr+1, last_ptr+2, ... mod 8.
  - Next cycle: state=GRANT, grant_vld=1, grant_idx=i, grant_onehot=(1<<i), hold_cnt=0, last_ptr=i.
  - Latency: req sampled high in cycle n gives grant visible in cycle n+1.
  - If en=0 or req==0: stay in IDLE with outputs 0.

- GRANT
  - hold_cnt increments each cycle.
  - Release when req[grant_idx]=0 is sampled: next cycle state=GAP, grant_vld=0, grant_onehot=0; grant_idx keeps its value.
  - Timeout when hold_cnt==MAX_HOLD-1 and req[grant_idx] is still 1: same transition to GAP, plus timeout=1 for exactly that GAP cycle.
  - The granted requester has now been served for MAX_HOLD cycles.
  - Release and timeout in the same cycle count as a release: timeout=0.
  - en=0 during GRANT does not revoke the grant.
  - Changes on other req bits during GRANT are ignored.

- GAP
  - Exactly one cycle with all enables low.
  - Arbitration is performed in this cycle with the same rule as IDLE (including the en gate).
  - Next cycle: new GRANT if a request is eligible, else IDLE.
  - Back-to-back grant spacing is therefore 1 dead cycle.

- Fairness: last_ptr is always the last granted index, so a timed-out or released requester is lowest priority in the next search. With all 8 requesting continuously, the grant order is 0,1,...,7,0.

- Width rules
  - Pointer arithmetic is mod 8 (3-bit wrap from 7 to 0).
  - hold_cnt never exceeds MAX_HOLD-1.
  - MAX_HOLD=1 gives single-cycle grants separated by GAP.

- Invariant: grant_onehot has popcount ≤ 1 in every cycle and equals 0 whenever grant_vld=0.

- Reset asserted mid-grant: outputs drop to 0 immediately (asynchronously); last_ptr returns to 7.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
  - NUM_REQ=8
  - IDX_W=3
- Sub-module rr_pick8: purely combinational.
  - Inputs: req[7:0], last_ptr[2:0].
  - Outputs: found, idx[2:0].
  - Rotate the request vector, priority-encode, rotate back.
- The one-hot enable is produced by instantiating the existing 3-to-8 decoder on the next grant_idx, ANDed with the next grant_vld, and then registered.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation → all outputs 0 asynchronously. After release with req=8'h00, outputs remain 0 and the state stays IDLE.
- Single requester: req=8'h04 for 5 cycles, then 0 → grant_idx=2 and grant_onehot=8'h04 from the cycle after the first request. After release, one GAP cycle, then IDLE; timeout never pulses.
- Round-robin: req=8'hFF held and each requester drops req 2 cycles after its grant → grant_idx sequence 0,1,2,...,7,0. Exactly one zero-enable cycle between grants; popcount(grant_onehot) ≤ 1 throughout.
- Timeout: MAX_HOLD=4, req=8'h81 held constantly → idx 7 is never first. Sequence is 0 for 4 cycles, timeout pulse in the GAP, then 7 for 4 cycles, timeout pulse, then 0 again.
- Enable gating: en=0 with req=8'h10 → no grant. Raise en → grant idx 4 next cycle. Drop en during the grant → grant persists until req[4] falls, then the scheduler returns to IDLE even though req[3] is now high.
- Wrap/priority: last grant idx 6, req=8'h41 in GAP → next grant 0 (search 7,0,...), not 6.

Source files
------------

// File: rtl/decoder_rr_scheduler_pkg.sv
// decoder_rr_scheduler_pkg: shared sizes and state encoding for the round-robin decoder scheduler.
package decoder_rr_scheduler_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;
endpackage

// File: rtl/decoder_rr_scheduler_dec3to8.sv
// dec3to8: plain 3-to-8 binary decoder driving the shared resource's enable lines.
module dec3to8
    import decoder_rr_scheduler_pkg::*;
(
    input  logic [IDX_W-1:0]   a_i,
    output logic [NUM_REQ-1:0] y_o
);
    assign y_o = NUM_REQ'(1) << a_i;
endmodule

// File: rtl/decoder_rr_scheduler_rr_pick8.sv
// rr_pick8: round-robin pick of the first request after last_ptr, searching upward mod 8.
module rr_pick8
    import decoder_rr_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0]   start;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   pos;
    always_comb begin
        start = last_ptr_i + IDX_W'(1);
        rot   = NUM_REQ'({req_i, req_i} >> start);
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) pos = IDX_W'(k);
        found_o = |req_i;
        idx_o   = pos + start;
    end
endmodule

// File: rtl/decoder_rr_scheduler.sv
// decoder_rr_scheduler: shares one decoder-driven resource among 8 requesters, round-robin,
// with a hold timeout and one dead cycle between grants.
module decoder_rr_scheduler
    import decoder_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic               grant_vld,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               timeout
);
    state_e             state_q, state_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] onehot_q, onehot_d, dec_y;
    logic               to_q, to_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick8 u_pick (
        .req_i      (req),
        .last_ptr_i (ptr_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        vld_d   = 1'b0;
        idx_d   = idx_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        case (state_q)
            ST_GRANT: begin
                state_d = ST_GAP;
                if (!req[idx_q]) begin
                    to_d = 1'b0;
                end else if (hold_q == CNT_W'(MAX_HOLD - 1)) begin
                    to_d = 1'b1;
                end else begin
                    state_d = ST_GRANT;
                    vld_d   = 1'b1;
                    hold_d  = hold_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; only GAP keeps the old index visible.
                state_d = (en && pick_found) ? ST_GRANT : ST_IDLE;
                vld_d   = en && pick_found;
                idx_d   = (en && pick_found) ? pick_idx : '0;
                hold_d  = '0;
                ptr_d   = (en && pick_found) ? pick_idx : ptr_q;
            end
        endcase
    end

    dec3to8 u_dec (
        .a_i (idx_d),
        .y_o (dec_y)
    );

    assign onehot_d = dec_y & {NUM_REQ{vld_d}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            to_q     <= 1'b0;
            hold_q   <= '0;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            to_q     <= to_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_vld    = vld_q;
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign timeout      = to_q;
endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// tb_decoder_rr_scheduler: two schedulers (MAX_HOLD 16 and 4) on shared inputs, checked
// every cycle against a behavioural model plus directed order/reset checks.
module tb_decoder_rr_scheduler;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [7:0]       req = 8'h00;
    logic [1:0]       o_vld;
    logic [1:0][2:0]  o_idx;
    logic [1:0][7:0]  o_oh;
    logic [1:0]       o_to;
    int               n_chk = 0;
    int               n_bad = 0;

    int  lim    [2] = '{16, 4};
    bit  busy   [2] = '{0, 0};
    bit  gap    [2] = '{0, 0};
    bit  to_e   [2] = '{0, 0};
    int  owner  [2] = '{0, 0};
    int  served [2] = '{0, 0};
    int  last   [2] = '{7, 7};

    always #5 clk = ~clk;

    decoder_rr_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant_vld(o_vld[0]), .grant_idx(o_idx[0]), .grant_onehot(o_oh[0]), .timeout(o_to[0])
    );

    decoder_rr_scheduler #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant_vld(o_vld[1]), .grant_idx(o_idx[1]), .grant_onehot(o_oh[1]), .timeout(o_to[1])
    );

    // Reference: who owns the resource, how long it has been served, who was served last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                busy[m] = 0; gap[m] = 0; to_e[m] = 0; owner[m] = 0; served[m] = 0; last[m] = 7;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (busy[m]) begin
                    if (!req[owner[m]]) begin
                        busy[m] = 0; gap[m] = 1; to_e[m] = 0;
                    end else if (served[m] == lim[m]) begin
                        busy[m] = 0; gap[m] = 1; to_e[m] = 1;
                    end else begin
                        served[m]++;
                    end
                end else begin
                    bit hit;
                    hit = 0; gap[m] = 0; to_e[m] = 0;
                    if (en) begin
                        for (int k = 1; k <= 8; k++) begin
                            int j;
                            j = (last[m] + k) % 8;
                            if (!hit && req[j]) begin
                                hit = 1; owner[m] = j;
                            end
                        end
                    end
                    if (hit) begin
                        busy[m] = 1; served[m] = 1; last[m] = owner[m];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("vld%0d", m), 32'(o_vld[m]), 32'(busy[m]));
            chk($sformatf("onehot%0d", m), 32'(o_oh[m]), busy[m] ? (32'd1 << owner[m]) : 32'd0);
            chk($sformatf("timeout%0d", m), 32'(o_to[m]), 32'(to_e[m]));
            if (busy[m] || gap[m]) chk($sformatf("idx%0d", m), 32'(o_idx[m]), 32'(owner[m]));
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_vld"}, 32'(o_vld[m]), 32'd0);
            chk({tag, "_idx"}, 32'(o_idx[m]), 32'd0);
            chk({tag, "_oh"},  32'(o_oh[m]),  32'd0);
            chk({tag, "_to"},  32'(o_to[m]),  32'd0);
        end
    endtask

    initial begin
        int seq [$];
        bit prev;
        #12 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        en = 1'b1;
        cyc(3);
        check_zero("idle");
        req = 8'h04; cyc(5);
        req = 8'h00; cyc(4);
        req = 8'h81; cyc(24);
        req = 8'h00; cyc(3);
        // enable gating, then en dropped mid-grant while req[3] shows up
        en = 1'b0; req = 8'h10; cyc(3);
        en = 1'b1; cyc(1);
        en = 1'b0; req = 8'h18; cyc(3);
        req = 8'h08; cyc(3);
        en = 1'b1; cyc(2);
        req = 8'h40; cyc(3);
        req = 8'h41; cyc(3);
        req = 8'h00; cyc(3);
        // async reset mid-grant
        req = 8'hFF; cyc(2);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        prev = 0;
        for (int i = 0; i < 60 && seq.size() < 9; i++) begin
            cyc(1);
            if (o_vld[1] && !prev) seq.push_back(int'(o_idx[1]));
            prev = o_vld[1];
        end
        chk("order_len", 32'(seq.size()), 32'd9);
        foreach (seq[k]) chk($sformatf("order%0d", k), 32'(seq[k]), 32'(k % 8));
        req = 8'h00; cyc(3);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 99) == 0) req = 8'h00;
            en = ($urandom_range(0, 7) != 0);
            cyc(1);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
